ff_train_sequencer: RTL and testbench

Top-level training scheduler for the Forward-Forward accelerator. It accepts a run command (sample count, epoch count) and sequences the per-layer datapath for each sample: load, forward pass, goodness, plasticity update. Each sample is processed once with positive polarity and once with negative polarity. It sits above the inference engine, goodness calculator and plasticity engine, and owns their start/done handshakes and the positive/negative flag.

---
 rtl/ff_train_sequencer.sv | 173 +++++++++++++++++
 tb/tb_ff_train_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ff_train_sequencer.sv
// ff_train_sequencer: training scheduler for the Forward-Forward accelerator.
// For each sample it runs a positive and then a negative pass. Each pass is a
// load followed by forward/goodness/plasticity for every layer. It owns the
// start/done handshakes of the engines below it and the polarity flag.
// Optional watchdog on every wait state: define FF_SEQ_WATCHDOG_EN.
module ff_train_sequencer #(
  parameter int NUM_LAYERS  = 2,
  parameter int SAMPLE_W    = 16,
  parameter int EPOCH_W     = 16,
  parameter int WDOG_CYCLES = 1048576,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [SAMPLE_W-1:0] cmd_num_samples,
  input  logic [EPOCH_W-1:0]  cmd_num_epochs,
  input  logic                abort,
  output logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_idx,
  output logic                sample_is_pos,
  input  logic                sample_ack,
  output logic [LW-1:0]       layer_sel,
  output logic                fwd_start,
  input  logic                fwd_done,
  output logic                good_start,
  input  logic                good_done,
  output logic                plast_start,
  input  logic                plast_done,
  output logic [EPOCH_W-1:0]  epoch_idx,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FWD, S_GOOD, S_UPD, S_ADV, S_FINISH
`ifdef FF_SEQ_WATCHDOG_EN
    , S_ERR
`endif
  } state_t;

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] num_samples_q;
  logic [EPOCH_W-1:0]  num_epochs_q;
  logic                zero_cmd, last_layer, last_sample, last_epoch;
  logic                abort_hit, err_go;

  assign zero_cmd    = (cmd_num_samples == '0) || (cmd_num_epochs == '0);
  assign last_layer  = (layer_sel == LW'(NUM_LAYERS - 1));
  // Wrap points come from the captured counts, not from counter overflow.
  assign last_sample = (sample_idx == num_samples_q - SAMPLE_W'(1));
  assign last_epoch  = (epoch_idx == num_epochs_q - EPOCH_W'(1));

`ifdef FF_SEQ_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wdog_cnt;
  logic           wait_st;
  assign wait_st   = (state == S_LOAD) || (state == S_FWD) ||
                     (state == S_GOOD) || (state == S_UPD);
  assign abort_hit = abort && (state != S_IDLE) && (state != S_FINISH) && (state != S_ERR);
  assign err_go    = (state_nxt == S_ERR);

  // Watchdog: restart on every state change, count while parked in a wait state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  wdog_cnt <= '0;
    else if (state_nxt != state) wdog_cnt <= '0;
    else if (wait_st)            wdog_cnt <= wdog_cnt + WCW'(1);
  end

  // Sticky error: set on watchdog expiry, cleared only by the next accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  error <= 1'b0;
    else if (state == S_IDLE && state_nxt != S_IDLE) error <= 1'b0;
    else if (err_go)                             error <= 1'b1;
  end
`else
  // Watchdog depth only matters when the watchdog is built in.
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES > 0);
  assign abort_hit   = abort && (state != S_IDLE) && (state != S_FINISH);
  assign err_go      = 1'b0;
  assign error       = 1'b0;
`endif

  // Next state. A done/ack is ignored in the start-pulse cycle of its own state,
  // so only responses to this state's request are accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (cmd_valid) state_nxt = zero_cmd ? S_FINISH : S_LOAD;
      S_LOAD:   if (sample_ack && !sample_req) state_nxt = S_FWD;
      S_FWD:    if (fwd_done && !fwd_start) state_nxt = S_GOOD;
      S_GOOD:   if (good_done && !good_start) state_nxt = S_UPD;
      S_UPD:    if (plast_done && !plast_start) state_nxt = last_layer ? S_ADV : S_FWD;
      S_ADV:    state_nxt = (!sample_is_pos && last_sample && last_epoch) ? S_FINISH : S_LOAD;
      S_FINISH: state_nxt = S_IDLE;
`ifdef FF_SEQ_WATCHDOG_EN
      S_ERR:    state_nxt = S_IDLE;
`endif
      default:  state_nxt = S_IDLE;
    endcase
`ifdef FF_SEQ_WATCHDOG_EN
    if (wait_st && state_nxt == state && wdog_cnt == WCW'(WDOG_CYCLES - 1)) state_nxt = S_ERR;
`endif
    // Abort wins over everything, including the watchdog.
    if (abort_hit) state_nxt = S_IDLE;
  end

  // State register and registered control outputs; start pulses fire on state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      sample_req  <= 1'b0;
      fwd_start   <= 1'b0;
      good_start  <= 1'b0;
      plast_start <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_ready   <= (state_nxt == S_IDLE);
      busy        <= (state_nxt != S_IDLE);
      sample_req  <= (state_nxt == S_LOAD) && (state != S_LOAD);
      fwd_start   <= (state_nxt == S_FWD)  && (state != S_FWD);
      good_start  <= (state_nxt == S_GOOD) && (state != S_GOOD);
      plast_start <= (state_nxt == S_UPD)  && (state != S_UPD);
      done        <= (state == S_FINISH);
      aborted     <= abort_hit || err_go;
    end
  end

  // Run bookkeeping: captured counts, sample/epoch/layer indices, polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_samples_q <= '0;
      num_epochs_q  <= '0;
      sample_idx    <= '0;
      epoch_idx     <= '0;
      layer_sel     <= '0;
      sample_is_pos <= 1'b1;
    end else begin
      if (state == S_IDLE && state_nxt != S_IDLE) begin
        num_samples_q <= cmd_num_samples;
        num_epochs_q  <= cmd_num_epochs;
        sample_idx    <= '0;
        epoch_idx     <= '0;
        layer_sel     <= '0;
        sample_is_pos <= 1'b1;
      end
      if (state == S_LOAD && state_nxt == S_FWD) layer_sel <= '0;
      if (state == S_UPD && state_nxt == S_FWD) layer_sel <= layer_sel + LW'(1);
      if (state == S_ADV && state_nxt != S_IDLE) begin
        if (sample_is_pos) begin
          sample_is_pos <= 1'b0;
        end else begin
          sample_is_pos <= 1'b1;
          if (last_sample) begin
            sample_idx <= '0;
            epoch_idx  <= epoch_idx + EPOCH_W'(1);
          end else begin
            sample_idx <= sample_idx + SAMPLE_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ff_train_sequencer.sv
// Bench for ff_train_sequencer: table of run commands with expected counts and
// done latency, a scoreboard of expected sample_req {idx, polarity, epoch},
// and hand-written abort / stray-done / watchdog sequences.
module tb_ff_train_sequencer;
  localparam int NL = 2, SW = 16, EW = 16, WD = 16, LW = 1, DLY = 3;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, abort;
  logic [SW-1:0] cmd_num_samples, sample_idx;
  logic [EW-1:0] cmd_num_epochs, epoch_idx;
  logic          sample_req, sample_is_pos, sample_ack;
  logic [LW-1:0] layer_sel;
  logic          fwd_start, fwd_done, good_start, good_done, plast_start, plast_done;
  logic          busy, done, aborted, error;

  ff_train_sequencer #(.NUM_LAYERS(NL), .SAMPLE_W(SW), .EPOCH_W(EW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_num_samples(cmd_num_samples), .cmd_num_epochs(cmd_num_epochs), .abort(abort),
    .sample_req(sample_req), .sample_idx(sample_idx), .sample_is_pos(sample_is_pos),
    .sample_ack(sample_ack), .layer_sel(layer_sel), .fwd_start(fwd_start), .fwd_done(fwd_done),
    .good_start(good_start), .good_done(good_done), .plast_start(plast_start),
    .plast_done(plast_done), .epoch_idx(epoch_idx), .busy(busy), .done(done),
    .aborted(aborted), .error(error));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model controls (written by the main process only).
  bit ack_en = 1, fwd_en = 1, good_en = 1, plast_en = 1, stray_en = 0, inj_good = 0;

  // Engine model: each engine answers DLY cycles after its start pulse with a
  // one-cycle done. Optional stray fwd_done in LOAD and in FWD's start cycle.
  initial begin
    int a_cnt, f_cnt, g_cnt, p_cnt;
    a_cnt = 0; f_cnt = 0; g_cnt = 0; p_cnt = 0;
    sample_ack = 0; fwd_done = 0; good_done = 0; plast_done = 0;
    forever begin
      @(negedge clk);
      sample_ack = 0; fwd_done = 0; good_done = 0; plast_done = 0;
      if (a_cnt > 0) begin a_cnt--; if (a_cnt == 0) sample_ack = 1; end
      if (f_cnt > 0) begin f_cnt--; if (f_cnt == 0) fwd_done = 1; end
      if (g_cnt > 0) begin g_cnt--; if (g_cnt == 0) good_done = 1; end
      if (p_cnt > 0) begin p_cnt--; if (p_cnt == 0) plast_done = 1; end
      if (rst_n === 1'b1) begin
        if (sample_req && ack_en)  a_cnt = DLY;
        if (fwd_start && fwd_en)   f_cnt = DLY;
        if (good_start && good_en) g_cnt = DLY;
        if (plast_start && plast_en) p_cnt = DLY;
        if (stray_en && (sample_req || fwd_start)) fwd_done = 1;
      end
      if (inj_good) good_done = 1;
    end
  end

  typedef struct { int idx; int pos; int ep; } req_t;
  typedef struct { int s; int e; int reqs; int plasts; int lat; } vec_t;

  req_t sb_q[$];
  int nc = 0, nf = 0;
  int exp_layer = 0, req_cnt = 0, plast_cnt = 0, done_cnt = 0, ab_cnt = 0;
  int done_cyc = 0, ab_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nc++;
    if (act != exp) begin
      nf++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor duties, run at every negedge by the main process.
  task automatic observe();
    req_t r;
    if (sample_req) begin
      chk("scoreboard has entry at sample_req", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        chk("sample_idx", sample_idx, r.idx);
        chk("sample_is_pos", sample_is_pos, r.pos);
        chk("epoch_idx", epoch_idx, r.ep);
      end
      exp_layer = 0;
      req_cnt++;
    end
    if (fwd_start) begin chk("layer_sel at fwd_start", layer_sel, exp_layer); exp_layer++; end
    if (plast_start) plast_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (aborted) begin ab_cnt++; ab_cyc = cyc; end
  endtask

  task automatic step();
    @(negedge clk);
    observe();
  endtask

  task automatic run_cmd(input int s, input int e, output int acc);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin step(); n++; end
    chk("cmd_ready before command", cmd_ready, 1);
    for (int ep = 0; ep < e; ep++)
      for (int i = 0; i < s; i++) begin
        sb_q.push_back('{i, 1, ep});
        sb_q.push_back('{i, 0, ep});
      end
    cmd_valid = 1; cmd_num_samples = SW'(s); cmd_num_epochs = EW'(e);
    acc = cyc;
    step();
    cmd_valid = 0;
  endtask

  task automatic run_check(input int s, input int e, input int reqs, input int plasts, input int lat);
    int acc, n, d0, p0, r0, a0;
    d0 = done_cnt; p0 = plast_cnt; r0 = req_cnt; a0 = ab_cnt;
    run_cmd(s, e, acc);
    n = 0;
    while (done_cnt == d0 && n < lat + 50) begin step(); n++; end
    chk("done pulse count", done_cnt - d0, 1);
    chk("done latency from accept", done_cyc - acc, lat);
    chk("sample_req count", req_cnt - r0, reqs);
    chk("plast_start count", plast_cnt - p0, plasts);
    chk("scoreboard drained", sb_q.size(), 0);
    chk("busy with done", busy, 0);
    chk("no aborted in normal run", ab_cnt - a0, 0);
    chk("error after normal run", error, 0);
    step();
    chk("done is one cycle", done, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int acc, n, d0, a0, r0, pc;
    tbl[0] = '{2, 1, 4, 8, 118};
    tbl[1] = '{0, 5, 0, 0, 2};
    tbl[2] = '{1, 3, 6, 12, 176};
    tbl[3] = '{3, 2, 12, 24, 350};
    tbl[4] = '{1, 1, 2, 4, 60};
    tbl[5] = '{4, 0, 0, 0, 2};

    cmd_valid = 0; cmd_num_samples = '0; cmd_num_epochs = '0; abort = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #2;
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset sample_req", sample_req, 0);
    chk("reset done", done, 0);
    chk("reset aborted", aborted, 0);
    chk("reset sample_idx", sample_idx, 0);
    chk("reset epoch_idx", epoch_idx, 0);
    chk("reset layer_sel", layer_sel, 0);
    chk("reset sample_is_pos", sample_is_pos, 1);
    chk("reset error", error, 0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    step();

    for (int i = 0; i < 6; i++)
      run_check(tbl[i].s, tbl[i].e, tbl[i].reqs, tbl[i].plasts, tbl[i].lat);

    // Abort while waiting on goodness for sample 0; a late good_done must be ignored.
    good_en = 0; d0 = done_cnt; a0 = ab_cnt;
    run_cmd(2, 1, acc);
    n = 0;
    while (!good_start && n < 100) begin step(); n++; end
    chk("good_start reached", good_start, 1);
    abort = 1;
    step();
    abort = 0;
    chk("aborted pulse after abort", aborted, 1);
    chk("cmd_ready after abort", cmd_ready, 1);
    chk("busy after abort", busy, 0);
    sb_q.delete();
    r0 = req_cnt;
    inj_good = 1; step(); step(); inj_good = 0;
    repeat (4) step();
    chk("idle after late good_done", busy, 0);
    chk("no sample_req after abort", req_cnt - r0, 0);
    chk("no done after abort", done_cnt - d0, 0);
    chk("single aborted pulse", ab_cnt - a0, 1);
    chk("aborted is one cycle", aborted, 0);
    good_en = 1;
    run_check(1, 1, 2, 4, 60);

    // Stray fwd_done in LOAD and in FWD's start cycle must not shorten the run.
    stray_en = 1;
    run_check(1, 1, 2, 4, 60);
    stray_en = 0;

`ifdef FF_SEQ_WATCHDOG_EN
    // Plasticity never answers: watchdog fires WD cycles after plast_start.
    plast_en = 0; a0 = ab_cnt;
    run_cmd(1, 1, acc);
    n = 0;
    while (!plast_start && n < 100) begin step(); n++; end
    chk("plast_start reached", plast_start, 1);
    pc = cyc;
    n = 0;
    while (ab_cnt == a0 && n < 60) begin step(); n++; end
    chk("watchdog aborted pulse", ab_cnt - a0, 1);
    chk("watchdog delay", ab_cyc - pc, WD);
    chk("error set by watchdog", error, 1);
    repeat (3) step();
    chk("error sticky in idle", error, 1);
    chk("cmd_ready after watchdog", cmd_ready, 1);
    sb_q.delete();
    plast_en = 1;
    run_check(1, 1, 2, 4, 60);
`else
    pc = 0;
    chk("error tied low", error, pc);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
    $finish;
  end

endmodule
